// File: rtl/wb_debounce_irq.sv
// Push-button front end with Wishbone register access: 2-FF sync, tick-paced
// per-channel debounce, edge-selectable sticky pending bits and masked interrupts.

module wb_debounce_irq_ch #(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic state,
  output logic rise,
  output logic fall
);
  logic [7:0] cnt;
  logic       accept;

  // cnt holds how many consecutive ticks have already disagreed with state
  assign accept = tick && (raw != state) && (cnt == 8'(STABLE_SAMPLES - 1));
  assign rise   = accept & raw;
  assign fall   = accept & ~raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (tick) begin
      if (raw == state) cnt <= '0;
      else if (accept) begin
        state <= raw;
        cnt   <= '0;
      end else cnt <= cnt + 8'd1;
    end
  end
endmodule

module wb_debounce_irq #(
  parameter int N_CH           = 5,
  parameter int TICK_DIV       = 1050000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     wb_adr_i,
  input  logic [31:0]     wb_dat_i,
  output logic [31:0]     wb_dat_o,
  input  logic [3:0]      wb_sel_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  input  logic            wb_we_i,
  output logic            wb_ack_o,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] irq_o,
  output logic            intr_o
);
  localparam int TW = $clog2(TICK_DIV);

  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [N_CH-1:0] sync1, raw, state, rise, fall;
  logic [N_CH-1:0] pending, mask, rise_en, fall_en;
  logic [N_CH-1:0] wm, wd, set, clr;
  logic [31:0]     rd_data;
  logic            req, wr;
  logic [2:0]      reg_sel;
  logic            unused_ok;

  assign unused_ok = &{1'b0, wb_adr_i, wb_dat_i};
  assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr        = req & wb_we_i;
  assign reg_sel   = wb_adr_i[4:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      raw      <= '0;
      tick_cnt <= '0;
    end else begin
      sync1    <= btn_i;
      raw      <= sync1;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    wb_debounce_irq_ch #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_ch (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .raw  (raw[i]),
      .state(state[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // channel bit i lives in byte lane i/8
  always_comb begin
    wm = '0;
    for (int i = 0; i < N_CH; i++) wm[i] = wb_sel_i[i/8];
  end

  assign wd  = wb_dat_i[N_CH-1:0] & wm;
  assign set = (rise & rise_en) | (fall & fall_en);
  assign clr = (wr && reg_sel == 3'd2) ? wd : '0;

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      3'd0:    rd_data[N_CH-1:0] = state;
      3'd1:    rd_data[N_CH-1:0] = raw;
      3'd2:    rd_data[N_CH-1:0] = pending;
      3'd3:    rd_data[N_CH-1:0] = mask;
      3'd4:    rd_data[N_CH-1:0] = rise_en;
      3'd5:    rd_data[N_CH-1:0] = fall_en;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      mask     <= '0;
      rise_en  <= '1;
      fall_en  <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      irq_o    <= '0;
      intr_o   <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= req ? rd_data : '0;
      // a new event outranks a same-cycle W1C so no edge is lost
      pending  <= (pending & ~clr) | set;
      irq_o    <= pending & mask;
      intr_o   <= |(pending & mask);
      if (wr && reg_sel == 3'd3) mask    <= (mask & ~wm) | wd;
      if (wr && reg_sel == 3'd4) rise_en <= (rise_en & ~wm) | wd;
      if (wr && reg_sel == 3'd5) fall_en <= (fall_en & ~wm) | wd;
    end
  end
endmodule
